// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        ZERO,
        DONE
    } state_t;

    // Quotient reported on divide-by-zero: all ones in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] zero_quot(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {A,Q} against divisor M.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        shifted = {a_i, q_i[WIDTH-1]};
        trial   = shifted - {1'b0, m_i};
        // A set top bit means shifted >= 2^WIDTH > M, so the subtract cannot borrow.
        fits    = shifted[WIDTH] | ~trial[WIDTH];
        a_o     = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_o     = {q_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed/unsigned,
// with divide-by-zero flag and packed {remainder, quotient} result.
module div_seq
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam logic [MAX_WIDTH-1:0] ZQ_FULL = zero_quot(WIDTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, q_q, q_d, m_q, m_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic              dz_q, dz_d, done_q, done_d;
    logic [WIDTH-1:0]  step_a, step_q;
    logic              dvd_neg, dvs_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        dvd_neg = signed_mode & dividend[WIDTH-1];
        dvs_neg = signed_mode & divisor[WIDTH-1];

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dz_d   = 1'b0;
                    cnt_d  = '0;
                    a_d    = '0;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    m_d    = dvs_neg ? -divisor : divisor;
                    if (divisor == '0) begin
                        // Raw dividend is parked in Q so ZERO can return it untouched.
                        q_d     = dividend;
                        state_d = ZERO;
                    end else begin
                        q_d     = dvd_neg ? -dividend : dividend;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                quot_d  = qneg_q ? -q_q : q_q;
                rem_d   = rneg_q ? -a_q : a_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            ZERO: begin
                quot_d  = ZQ_FULL[WIDTH-1:0];
                rem_d   = q_q;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX) || (state_q == ZERO);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign result      = {rem_q, quot_q};
    assign div_by_zero = dz_q;

endmodule
